// File: rtl/divider.sv
// Sequential signed divider: one quotient bit per clock using non-restoring
// division on operand magnitudes, with a final restore and sign fix-up cycle.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   Dvnd,
    input  logic [WIDTH-1:0]   Dvsr,
    output logic [2*WIDTH-1:0] Y,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, next_state;

    // Partial remainder carries one extra bit so its sign can steer add/subtract.
    logic [WIDTH:0]   rem;
    // Holds the dividend magnitude at start; quotient bits shift in from the right.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr_mag;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             zero_dvsr;

    logic [WIDTH:0]   dvsr_ext;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH:0]   rem_fixed;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] r_out;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // One non-restoring step plus the final restore and sign correction.
    always_comb begin
        dvsr_ext  = {1'b0, dvsr_mag};
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_step  = rem[WIDTH] ? (rem_shift + dvsr_ext) : (rem_shift - dvsr_ext);
        rem_fixed = rem[WIDTH] ? (rem + dvsr_ext) : rem;
        if (zero_dvsr) begin
            // No iterations ran, so quo still holds |Dvnd|; remainder becomes Dvnd.
            q_out = '1;
            r_mag = quo;
        end else begin
            q_out = neg_q ? (-quo) : quo;
            r_mag = rem_fixed[WIDTH-1:0];
        end
        r_out = neg_r ? (-r_mag) : r_mag;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a zero divisor skips the iteration phase entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (Dvsr == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_ITER) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture magnitudes on start, iterate in CALC, publish in FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem         <= '0;
            quo         <= '0;
            dvsr_mag    <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_dvsr   <= 1'b0;
            Y           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem       <= '0;
                        quo       <= Dvnd[WIDTH-1] ? (-Dvnd) : Dvnd;
                        dvsr_mag  <= Dvsr[WIDTH-1] ? (-Dvsr) : Dvsr;
                        cnt       <= '0;
                        neg_q     <= Dvnd[WIDTH-1] ^ Dvsr[WIDTH-1];
                        neg_r     <= Dvnd[WIDTH-1];
                        zero_dvsr <= (Dvsr == '0);
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    Y           <= {r_out, q_out};
                    div_by_zero <= zero_dvsr;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
